// File: rtl/fp_mult_pkg.sv
// Shared types and the operand classifier for the sequential binary32 multiply front end.
// FP_MULT_DENORM_EN: keep denormals (hidden bit 0, effective exponent 1) instead of flushing them.
package fp_mult_pkg;

  localparam int BIAS = 127;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } unpacked_t;

  function automatic unpacked_t classify(input logic [31:0] x);
    unpacked_t   u;
    logic [7:0]  e;
    logic [22:0] m;
    e = x[30:23];
    m = x[22:0];
    u.sign    = x[31];
    u.exp     = e;
    u.sig     = {(e != 8'd0), m};
    u.is_nan  = (e == EXP_MAX) && (m != 23'd0);
    u.is_inf  = (e == EXP_MAX) && (m == 23'd0);
    u.is_zero = (e == 8'd0) && (m == 23'd0);
    if ((e == 8'd0) && (m != 23'd0)) begin
`ifdef FP_MULT_DENORM_EN
      // A denormal scales like exponent 1 with no hidden bit.
      u.exp = 8'd1;
`else
      u.sig     = 24'd0;
      u.is_zero = 1'b1;
`endif
    end
    return u;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpacker: splits one binary32 word into sign, exponent, significand and class flags.
module fp_unpack
  import fp_mult_pkg::*;
(
  input  logic [31:0] x,
  output unpacked_t   u
);

  assign u = classify(x);

endmodule

// File: rtl/fp_mult_mantissa_seq.sv
// Iterative shift-add significand multiplier with exponent sum and special-case flags.
// Denormal handling follows FP_MULT_DENORM_EN (see fp_mult_pkg).
module fp_mult_mantissa_seq
  import fp_mult_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [47:0] P,
  output logic [9:0]  S,
  output logic        sign,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int N     = 24 / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [23:0]        ma_reg, mb_reg;
  logic [47:0]        acc_reg;
  logic [9:0]         s_reg;
  logic               sign_reg, zero_reg, inf_reg, nan_reg;

  logic [31:0]        op_word [2];
  unpacked_t          op_unp  [2];

  assign op_word[0] = a;
  assign op_word[1] = b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      fp_unpack u_unpack (
        .x (op_word[gi]),
        .u (op_unp[gi])
      );
    end
  endgenerate

  logic       nan_next, inf_next, zero_next;
  logic [9:0] s_next;

  always_comb begin
    nan_next  = op_unp[0].is_nan | op_unp[1].is_nan
              | (op_unp[0].is_inf & op_unp[1].is_zero)
              | (op_unp[1].is_inf & op_unp[0].is_zero);
    inf_next  = !nan_next && (op_unp[0].is_inf | op_unp[1].is_inf);
    zero_next = !nan_next && !inf_next && (op_unp[0].is_zero | op_unp[1].is_zero);
    s_next    = {2'b00, op_unp[0].exp} + {2'b00, op_unp[1].exp} - 10'(BIAS);
  end

  logic        accept;
  logic        last_iter;
  logic [47:0] pp_base;
  logic [5:0]  pp_shamt;
  logic [47:0] pp_aligned;

  assign accept     = in_valid && in_ready;
  assign last_iter  = (cnt_reg == CNT_W'(N - 1));
  // Partial product of the low STEP multiplier bits, placed at this iteration's weight.
  assign pp_base    = {24'd0, ma_reg} * {{(48 - STEP){1'b0}}, mb_reg[STEP-1:0]};
  assign pp_shamt   = 6'(cnt_reg * STEP);
  assign pp_aligned = pp_base << pp_shamt;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_next = BUSY;
      end
      BUSY: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      ma_reg   <= '0;
      mb_reg   <= '0;
      acc_reg  <= '0;
      s_reg    <= '0;
      sign_reg <= 1'b0;
      zero_reg <= 1'b0;
      inf_reg  <= 1'b0;
      nan_reg  <= 1'b0;
    end else if (accept) begin
      cnt_reg  <= '0;
      ma_reg   <= op_unp[0].sig;
      mb_reg   <= op_unp[1].sig;
      acc_reg  <= '0;
      s_reg    <= s_next;
      sign_reg <= op_unp[0].sign ^ op_unp[1].sign;
      zero_reg <= zero_next;
      inf_reg  <= inf_next;
      nan_reg  <= nan_next;
    end else if (state_reg == BUSY) begin
      acc_reg <= acc_reg + pp_aligned;
      mb_reg  <= mb_reg >> STEP;
      cnt_reg <= last_iter ? '0 : cnt_reg + 1'b1;
    end
  end

  assign P       = acc_reg;
  assign S       = s_reg;
  assign sign    = sign_reg;
  assign is_zero = zero_reg;
  assign is_inf  = inf_reg;
  assign is_nan  = nan_reg;

endmodule

// File: tb/tb_fp_mult_mantissa_seq.sv
// Scoreboard bench for fp_mult_mantissa_seq: arithmetic reference model, random back-pressure, reset abort.
`timescale 1ns/1ps
module tb_fp_mult_mantissa_seq;

  localparam int STEP = 2;
  localparam int N    = 24 / STEP;
`ifdef FP_MULT_DENORM_EN
  localparam bit DEN = 1'b1;
`else
  localparam bit DEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] P;
  logic [9:0]  S;
  logic        sign, is_zero, is_inf, is_nan;
  logic        out_valid;
  logic        out_ready = 1'b0;

  fp_mult_mantissa_seq #(.STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .S         (S),
    .sign      (sign),
    .is_zero   (is_zero),
    .is_inf    (is_inf),
    .is_nan    (is_nan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] p;
    logic [9:0]  s;
    logic        sg, z, i, n;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   hold_left = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: IEEE field decode and an ordinary integer multiply.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    int ex, ey, fx, fy, effx, effy, s;
    longint unsigned sx, sy;
    bit nanx, nany, infx, infy, zx, zy;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    fx = int'(x[22:0]);  fy = int'(y[22:0]);
    nanx = (ex == 255) && (fx != 0);  nany = (ey == 255) && (fy != 0);
    infx = (ex == 255) && (fx == 0);  infy = (ey == 255) && (fy == 0);
    zx = (ex == 0) && ((fx == 0) || !DEN);
    zy = (ey == 0) && ((fy == 0) || !DEN);
    sx = (ex == 0) ? (DEN ? longint'(fx) : 0) : (longint'(1) << 23) + longint'(fx);
    sy = (ey == 0) ? (DEN ? longint'(fy) : 0) : (longint'(1) << 23) + longint'(fy);
    effx = (DEN && ex == 0 && fx != 0) ? 1 : ex;
    effy = (DEN && ey == 0 && fy != 0) ? 1 : ey;
    s = effx + effy - 127;
    r.p  = 48'(sx * sy);
    r.s  = 10'(s);
    r.sg = x[31] ^ y[31];
    r.n  = nanx || nany || (infx && zy) || (infy && zx);
    r.i  = !r.n && (infx || infy);
    r.z  = !r.n && !r.i && (zx || zy);
    r.acc_cyc = 0;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: v[30:0] = 31'd0;
      1: v[30:23] = 8'd0;
      2: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      3: v[30:23] = 8'hFF;
      default: ;
    endcase
    return v;
  endfunction

  task automatic issue(input logic [31:0] oa, input logic [31:0] ob, input bit push, input int junk);
    int guard;
    exp_t e;
    guard = 0;
    while (!in_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    a = oa; b = ob; in_valid = 1'b1;
    @(posedge clk); #1;
    if (push) begin
      e = model(oa, ob);
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    for (int j = 0; j < junk; j++) begin
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // out_ready decided just after each edge; random unless a hold is requested.
  always begin
    @(posedge clk); #2;
    if (out_valid) begin
      if (hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end else begin
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: latency, stability under back-pressure and result contents.
  bit          prev_valid = 1'b0;
  bit          snap_ok    = 1'b0;
  logic [47:0] snap_p;
  logic [9:0]  snap_s;
  logic [3:0]  snap_f;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      snap_ok    = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_while_valid", 64'(in_ready), 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!prev_valid) check("latency", 64'(cyc - sb[0].acc_cyc), 64'(N));
          if (snap_ok) begin
            check("hold_P", 64'(P), 64'(snap_p));
            check("hold_S", 64'(S), 64'(snap_s));
            check("hold_flags", 64'({sign, is_zero, is_inf, is_nan}), 64'(snap_f));
          end
          if (out_ready) begin
            e = sb.pop_front();
            check("P", 64'(P), 64'(e.p));
            check("S", 64'(S), 64'(e.s));
            check("sign", 64'(sign), 64'(e.sg));
            check("flags", 64'({is_zero, is_inf, is_nan}), 64'({e.z, e.i, e.n}));
            $display("xfer P=%012h S=%03h sign=%0b z/i/n=%0b%0b%0b", P, S, sign, is_zero, is_inf, is_nan);
            snap_ok = 1'b0;
          end else begin
            snap_p  = P;
            snap_s  = S;
            snap_f  = {sign, is_zero, is_inf, is_nan};
            snap_ok = 1'b1;
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  logic [31:0] dir_a [11] = '{32'h3F800000, 32'h3FC00000, 32'hC0000000, 32'h0D800000, 32'h00000001,
                              32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7F7FFFFF,
                              32'h00800000};
  logic [31:0] dir_b [11] = '{32'h3F800000, 32'h3FC00000, 32'h40400000, 32'h0D800000, 32'h3F800000,
                              32'h00000000, 32'h3F800000, 32'h40000000, 32'h42F60000, 32'h7F7FFFFF,
                              32'h00800000};

  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("in_ready_in_reset", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_P", 64'(P), 64'd0);
    check("reset_S", 64'(S), 64'd0);
    check("reset_flags", 64'({sign, is_zero, is_inf, is_nan}), 64'd0);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    for (int k = 0; k < 11; k++) issue(dir_a[k], dir_b[k], 1'b1, 3);

    hold_left = 5;
    issue(32'h3F800000, 32'h40000000, 1'b1, 0);

    // Abort: reset lands on the third BUSY edge; the result must never appear.
    guard = 0;
    while (!(in_ready && sb.size() == 0) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    issue(32'h40400000, 32'h40A00000, 1'b0, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("in_ready_abort_rst", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_P", 64'(P), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < N + 2; k++) begin
      check("abort_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    issue(32'h3F800000, 32'h3FC00000, 1'b1, 0);

    for (int k = 0; k < 40; k++) issue(rand_op(), rand_op(), 1'b1, $urandom_range(0, 3));

    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
